tm1638_responder: RTL and testbench

TM1638_RESPONDER -- requirements
Module: tm1638_responder

---
 rtl/tm1638_responder_if.sv | 11 +
 rtl/tm1638_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_tm1638_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tm1638_responder_if.sv
// Serial pin bundle between a TM1638-style controller and the responder.
interface tm1638_responder_if;
    logic sck;
    logic cs;
    logic dio_i;
    logic dio_o;
    logic dio_e;

    modport master (output sck, cs, dio_i, input dio_o, dio_e);
    modport slave  (input sck, cs, dio_i, output dio_o, dio_e);
endinterface

// File: rtl/tm1638_responder.sv
// TM1638-compatible serial slave: display memory/control writes and key-scan reads.
// Define TM1638_RESP_STATS_EN to add saturating frame_count/error_count outputs.
module tm1638_responder #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned NUM_KEY_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    tm1638_responder_if.slave          bus,
    input  logic [8*NUM_KEY_BYTES-1:0] key_data,
    output logic [7:0]                 disp_mem [16],
    output logic                       display_on,
    output logic [2:0]                 brightness,
    output logic                       frame_error
`ifdef TM1638_RESP_STATS_EN
    ,
    output logic [15:0]                frame_count,
    output logic [15:0]                error_count
`endif
);

    localparam int unsigned KEY_BITS = 8 * NUM_KEY_BYTES;
    localparam int unsigned RD_W     = $clog2(KEY_BITS);

    typedef enum logic [2:0] {
        S_WAIT_CS, S_IDLE, S_CMD, S_WDATA, S_RDATA, S_IGNORE
    } state_e;

    // Pin synchronizers; settle_q marks when they carry real pin samples after reset.
    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, dio_sync_q, settle_q;
    logic                   sck_prev_q, cs_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q <= '1;
            cs_sync_q  <= '1;
            dio_sync_q <= '1;
            settle_q   <= '0;
            sck_prev_q <= 1'b1;
            cs_prev_q  <= 1'b1;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
            dio_sync_q <= {dio_sync_q[SYNC_STAGES-2:0], bus.dio_i};
            settle_q   <= {settle_q[SYNC_STAGES-2:0], 1'b1};
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sck_s, cs_s, dio_s, settled;
    logic sck_rise, sck_fall, cs_rise, cs_fall;
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign dio_s    = dio_sync_q[SYNC_STAGES-1];
    assign settled  = settle_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;

    state_e              state_q, state_d;
    logic [7:0]          shift_q, shift_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [3:0]          ptr_q, ptr_d;
    logic                auto_inc_q, auto_inc_d;
    logic                disp_on_q, disp_on_d;
    logic [2:0]          bright_q, bright_d;
    logic                frame_error_q, frame_error_d;
    logic                dio_o_q, dio_o_d;
    logic                dio_e_q, dio_e_d;
    logic [KEY_BITS-1:0] snap_q, snap_d;
    logic [RD_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic [7:0]          disp_mem_q [16];
    logic [7:0]          disp_mem_d [16];
    logic [7:0]          byte_c;

    assign byte_c = {dio_s, shift_q[7:1]};

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        ptr_d         = ptr_q;
        auto_inc_d    = auto_inc_q;
        disp_on_d     = disp_on_q;
        bright_d      = bright_q;
        frame_error_d = 1'b0;
        dio_o_d       = dio_o_q;
        dio_e_d       = dio_e_q;
        snap_d        = snap_q;
        rd_cnt_d      = rd_cnt_q;
        disp_mem_d    = disp_mem_q;

        // A cs rising edge ends the frame from any state and masks a coincident sck edge.
        if (cs_rise) begin
            state_d       = S_IDLE;
            dio_e_d       = 1'b0;
            dio_o_d       = 1'b0;
            bit_cnt_d     = 3'd0;
            frame_error_d = (bit_cnt_q != 3'd0);
        end else begin
            case (state_q)
                S_WAIT_CS: if (settled && cs_s) state_d = S_IDLE;
                S_IDLE: begin
                    if (cs_fall) begin
                        state_d   = S_CMD;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_CMD: begin
                    if (sck_rise) begin
                        shift_d   = byte_c;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_IGNORE;
                            case (byte_c[7:6])
                                2'b01: begin
                                    auto_inc_d = ~byte_c[2];
                                    if (byte_c[1:0] == 2'b10) begin
                                        state_d  = S_RDATA;
                                        snap_d   = key_data;
                                        rd_cnt_d = '0;
                                        dio_e_d  = 1'b1;
                                    end
                                end
                                2'b10: begin
                                    disp_on_d = byte_c[3];
                                    bright_d  = byte_c[2:0];
                                end
                                2'b11: begin
                                    ptr_d   = byte_c[3:0];
                                    state_d = S_WDATA;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_WDATA: begin
                    if (sck_rise) begin
                        shift_d   = byte_c;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            disp_mem_d[ptr_q] = byte_c;
                            if (auto_inc_q) ptr_d = ptr_q + 4'd1;
                        end
                    end
                end
                S_RDATA: begin
                    // Drive on falling edges, count controller samples on rising edges.
                    if (sck_fall) begin
                        dio_o_d = snap_q[0];
                        snap_d  = snap_q >> 1;
                    end else if (sck_rise) begin
                        rd_cnt_d = rd_cnt_q + RD_W'(1);
                        if (rd_cnt_q == RD_W'(KEY_BITS - 1)) begin
                            state_d = S_IGNORE;
                            dio_e_d = 1'b0;
                            dio_o_d = 1'b0;
                        end
                    end
                end
                S_IGNORE: ;
                default: state_d = S_WAIT_CS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_WAIT_CS;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            ptr_q         <= '0;
            auto_inc_q    <= 1'b1;
            disp_on_q     <= 1'b0;
            bright_q      <= '0;
            frame_error_q <= 1'b0;
            dio_o_q       <= 1'b0;
            dio_e_q       <= 1'b0;
            snap_q        <= '0;
            rd_cnt_q      <= '0;
            disp_mem_q    <= '{default: '0};
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            ptr_q         <= ptr_d;
            auto_inc_q    <= auto_inc_d;
            disp_on_q     <= disp_on_d;
            bright_q      <= bright_d;
            frame_error_q <= frame_error_d;
            dio_o_q       <= dio_o_d;
            dio_e_q       <= dio_e_d;
            snap_q        <= snap_d;
            rd_cnt_q      <= rd_cnt_d;
            disp_mem_q    <= disp_mem_d;
        end
    end

    assign bus.dio_o   = dio_o_q;
    assign bus.dio_e   = dio_e_q;
    assign disp_mem    = disp_mem_q;
    assign display_on  = disp_on_q;
    assign brightness  = bright_q;
    assign frame_error = frame_error_q;

`ifdef TM1638_RESP_STATS_EN
    // Saturating frame and error statistics.
    logic [15:0] frame_count_q, error_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count_q <= '0;
            error_count_q <= '0;
        end else begin
            if (cs_rise && frame_count_q != 16'hFFFF) frame_count_q <= frame_count_q + 16'd1;
            if (frame_error_q && error_count_q != 16'hFFFF) error_count_q <= error_count_q + 16'd1;
        end
    end

    assign frame_count = frame_count_q;
    assign error_count = error_count_q;
`endif

endmodule

// File: tb/tb_tm1638_responder.sv
// Bench for tm1638_responder: directed frames plus random frames against a byte-level model.
module tb_tm1638_responder;

    localparam int unsigned NKB  = 4;
    localparam int unsigned KB   = 8 * NKB;
    localparam int unsigned HALF = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [KB-1:0] key_data;
    logic [7:0]    disp_mem [16];
    logic          display_on;
    logic [2:0]    brightness;
    logic          frame_error;
`ifdef TM1638_RESP_STATS_EN
    logic [15:0]   frame_count, error_count;
`endif

    always #5 clk = ~clk;

    tm1638_responder_if bus();

    tm1638_responder #(.SYNC_STAGES(2), .NUM_KEY_BYTES(NKB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .key_data   (key_data),
        .disp_mem   (disp_mem),
        .display_on (display_on),
        .brightness (brightness),
        .frame_error(frame_error)
`ifdef TM1638_RESP_STATS_EN
        ,
        .frame_count(frame_count),
        .error_count(error_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    int fe_cycles = 0;
    int m_fe = 0;

    // Reference model state: what the display memory and control should hold.
    logic [7:0] m_mem [16];
    int         m_ptr;
    logic       m_auto;
    logic       m_on;
    logic [2:0] m_br;

    always @(posedge clk) if (frame_error === 1'b1) fe_cycles++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_ptr = 0; m_auto = 1'b1; m_on = 1'b0; m_br = 3'd0;
    endtask

    task automatic model_frame(input logic [7:0] b [8], input int n);
        logic [7:0] cmd;
        if (n == 0) return;
        cmd = b[0];
        case (cmd[7:6])
            2'b01: m_auto = ~cmd[2];
            2'b10: begin m_on = cmd[3]; m_br = cmd[2:0]; end
            2'b11: begin
                m_ptr = int'(cmd[3:0]);
                for (int i = 1; i < n; i++) begin
                    m_mem[m_ptr] = b[i];
                    if (m_auto) m_ptr = (m_ptr + 1) % 16;
                end
            end
            default: ;
        endcase
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.sck = 1'b0; bus.dio_i = b; wait_clk(HALF);
        bus.sck = 1'b1; wait_clk(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic cs_low();
        bus.cs = 1'b0; wait_clk(HALF);
    endtask

    task automatic cs_high();
        bus.cs = 1'b1; wait_clk(2 * HALF);
    endtask

    task automatic run_frame(input logic [7:0] b [8], input int n);
        cs_low();
        for (int i = 0; i < n; i++) send_byte(b[i]);
        cs_high();
        model_frame(b, n);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s_mem%0d", tag, i), 32'(disp_mem[i]), 32'(m_mem[i]));
        check({tag, "_on"}, 32'(display_on), 32'(m_on));
        check({tag, "_br"}, 32'(brightness), 32'(m_br));
        check({tag, "_fe_total"}, fe_cycles, m_fe);
    endtask

    task automatic do_read(input logic [KB-1:0] kd, input logic fixed);
        logic [7:0]    cmd;
        logic [KB-1:0] got;
        cmd = 8'h42;
        cmd[2] = fixed;
        got = '0;
        key_data = kd;
        cs_low();
        for (int i = 0; i < 8; i++) begin
            send_bit(cmd[i]);
            if (i == 6) check("rd_dio_e_cmd", 32'(bus.dio_e), 32'd0);
        end
        check("rd_dio_e_start", 32'(bus.dio_e), 32'd1);
        m_auto = ~fixed;
        for (int i = 0; i < int'(KB); i++) begin
            bus.sck = 1'b0; wait_clk(HALF);
            got[i] = bus.dio_o;
            if (i == int'(KB) - 1) check("rd_dio_e_last", 32'(bus.dio_e), 32'd1);
            bus.sck = 1'b1; wait_clk(HALF);
            if (i == 0) key_data = KB'($urandom);
        end
        check("rd_data", 32'(got), 32'(kd));
        check("rd_dio_e_end", 32'(bus.dio_e), 32'd0);
        cs_high();
    endtask

    logic [7:0] fb [8];
    int         n, kind, fe0;

    initial begin
        bus.sck = 1'b1; bus.cs = 1'b1; bus.dio_i = 1'b0;
        key_data = '0;
        model_reset();
        wait_clk(4);
        check_all("reset");
        check("reset_dio_e", 32'(bus.dio_e), 32'd0);
        check("reset_dio_o", 32'(bus.dio_o), 32'd0);
        reset_n = 1'b1;
        wait_clk(8);

        // Basic write with auto-increment.
        fb = '{default: 8'h00};
        fb[0] = 8'h40; run_frame(fb, 1);
        fb[0] = 8'hC0; fb[1] = 8'h3F; fb[2] = 8'h06; fb[3] = 8'h5B; fb[4] = 8'h4F;
        run_frame(fb, 5);
        check_all("seq");

        // Address wrap 15 -> 0.
        fb[0] = 8'h40; run_frame(fb, 1);
        fb[0] = 8'hCF; fb[1] = 8'hAA; fb[2] = 8'hBB; run_frame(fb, 3);
        check_all("wrap");

        // Fixed address mode.
        fb[0] = 8'h44; run_frame(fb, 1);
        fb[0] = 8'hC5; fb[1] = 8'h11; fb[2] = 8'h22; run_frame(fb, 3);
        check_all("fixed");

        do_read(32'h04030201, 1'b0);
        check_all("read");

        fb[0] = 8'h8F; run_frame(fb, 1);
        check_all("disp8f");
        fb[0] = 8'h88; run_frame(fb, 1);
        check_all("disp88");

        // Partial command byte: dropped with a single frame_error pulse.
        fe0 = fe_cycles;
        fb[0] = 8'hC3;
        cs_low();
        for (int i = 0; i < 5; i++) send_bit(fb[0][i]);
        cs_high();
        m_fe++;
        check("partial_pulse", fe_cycles - fe0, 1);
        check_all("partial");

        for (int it = 0; it < 30; it++) begin
            for (int j = 0; j < 8; j++) fb[j] = 8'($urandom);
            kind = int'($urandom_range(0, 4));
            n = 1;
            case (kind)
                0: fb[0] = {2'b01, fb[0][5:2], 2'b00};
                1: begin fb[0][7:6] = 2'b11; n = int'($urandom_range(2, 6)); end
                2: begin fb[0][7:6] = 2'b10; n = int'($urandom_range(1, 2)); end
                3: begin fb[0][7:6] = 2'b00; n = int'($urandom_range(1, 3)); end
                default: ;
            endcase
            if (kind == 4) do_read(KB'($urandom), 1'($urandom));
            else run_frame(fb, n);
            check_all($sformatf("rnd%0d", it));
        end

        // Reset in the middle of a read; the frame still open afterwards is ignored.
        fe0 = fe_cycles;
        fb[0] = 8'h42;
        key_data = KB'($urandom);
        cs_low();
        send_byte(fb[0]);
        for (int i = 0; i < 10; i++) send_bit(1'b0);
        reset_n = 1'b0;
        #1;
        check("rst_dio_e", 32'(bus.dio_e), 32'd0);
        model_reset();
        check_all("rst_during");
        wait_clk(3);
        reset_n = 1'b1;
        send_byte(8'hC0);
        send_byte(8'h55);
        check_all("rst_open");
        cs_high();
        check("rst_no_fe", fe_cycles - fe0, 0);
        fb[0] = 8'hC0; fb[1] = 8'h77; run_frame(fb, 2);
        check_all("rst_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
